block_transfer_ctrl: RTL and testbench

Multi-cycle sequencer for ARM block transfers (STMDB-style push, LDMIA-style pop) over the 15-entry register file (r0–r14). On a start request it walks a register list lowest-first and issues one memory access per listed register. It drives the register-file read select for stores and the write-back port for loads and for the final base update. `busy` stalls the pipeline for the whole transfer.

---
 rtl/block_transfer_ctrl_if.sv | 35 +++
 rtl/block_transfer_ctrl.sv | 148 ++++++++++++++
 tb/tb_block_transfer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_transfer_ctrl_if.sv
// Block transfer controller bus: start request, memory port, write-back.
// The master is the pipeline/memory side; the slave is the sequencer.
interface block_transfer_ctrl_if;
    logic        start;
    logic        isLoad;
    logic [15:0] regList;
    logic [31:0] baseIn;
    logic [3:0]  baseReg;
    logic        writeBack;
    logic        memReady;
    logic [31:0] memRdata;
    logic        busy;
    logic [3:0]  regSel;
    logic [31:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic        wbEn;
    logic [3:0]  wbDest;
    logic [31:0] wbData;
    logic        done;

    modport master (
        output start, isLoad, regList, baseIn, baseReg, writeBack,
        output memReady, memRdata,
        input  busy, regSel, memAddr, memRead, memWrite,
        input  wbEn, wbDest, wbData, done
    );

    modport slave (
        input  start, isLoad, regList, baseIn, baseReg, writeBack,
        input  memReady, memRdata,
        output busy, regSel, memAddr, memRead, memWrite,
        output wbEn, wbDest, wbData, done
    );
endinterface

// File: rtl/block_transfer_ctrl.sv
// LDMIA/STMDB block transfer sequencer over r0-r14.
// Walks the register list lowest-first, one memory access per register.
module block_transfer_ctrl (
    input  logic clk,
    input  logic rst,
    block_transfer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, BASEWB, DONE} state_t;

    state_t      state_q, state_d;
    logic [14:0] pending_q, pending_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] final_q, final_d;
    logic        isLoad_q, isLoad_d;
    logic        wback_q, wback_d;
    logic        hit_q, hit_d;
    logic [3:0]  base_q, base_d;
    logic        wbEn_q, wbEn_d;
    logic [3:0]  wbDest_q, wbDest_d;
    logic [31:0] wbData_q, wbData_d;

    logic [3:0]  cnt;
    logic [3:0]  cur;
    logic [31:0] span;
    logic [15:0] listExt;
    logic [14:0] pendingNext;
    logic        xfer;
    logic        unused_pc;

    // Register count of the request and lowest still-pending register
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 15; i++) begin
            cnt = cnt + 4'(bus.regList[i]);
        end
        cur = '0;
        for (int i = 14; i >= 0; i--) begin
            if (pending_q[i]) cur = 4'(i);
        end
    end

    // r15 has no home in this register file; bit 15 never enters the list
    assign unused_pc   = bus.regList[15];
    assign listExt     = {1'b0, bus.regList[14:0]};
    assign span        = {26'b0, cnt, 2'b00};
    assign pendingNext = pending_q & (pending_q - 15'd1);
    assign xfer        = (state_q == XFER);

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        final_d   = final_q;
        isLoad_d  = isLoad_q;
        wback_d   = wback_q;
        hit_d     = hit_q;
        base_d    = base_q;
        wbEn_d    = 1'b0;
        wbDest_d  = wbDest_q;
        wbData_d  = wbData_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    isLoad_d  = bus.isLoad;
                    wback_d   = bus.writeBack;
                    base_d    = bus.baseReg;
                    pending_d = bus.regList[14:0];
                    hit_d     = bus.isLoad && listExt[bus.baseReg];
                    if (bus.isLoad) begin
                        final_d = bus.baseIn + span;
                        addr_d  = bus.baseIn;
                    end else begin
                        final_d = bus.baseIn - span;
                        addr_d  = bus.baseIn - span;
                    end
                    state_d = (cnt == 4'd0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (bus.memReady) begin
                    pending_d = pendingNext;
                    addr_d    = addr_q + 32'd4;
                    if (isLoad_q) begin
                        wbEn_d   = 1'b1;
                        wbDest_d = cur;
                        wbData_d = bus.memRdata;
                    end
                    if (pendingNext == '0) state_d = BASEWB;
                end
            end
            BASEWB: begin
                // A loaded base value takes priority over the base update
                if (wback_q && !hit_q) begin
                    wbEn_d   = 1'b1;
                    wbDest_d = base_q;
                    wbData_d = final_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            final_q   <= '0;
            isLoad_q  <= 1'b0;
            wback_q   <= 1'b0;
            hit_q     <= 1'b0;
            base_q    <= '0;
            wbEn_q    <= 1'b0;
            wbDest_q  <= '0;
            wbData_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            final_q   <= final_d;
            isLoad_q  <= isLoad_d;
            wback_q   <= wback_d;
            hit_q     <= hit_d;
            base_q    <= base_d;
            wbEn_q    <= wbEn_d;
            wbDest_q  <= wbDest_d;
            wbData_q  <= wbData_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.memRead  = xfer && isLoad_q;
    assign bus.memWrite = xfer && !isLoad_q;
    assign bus.regSel   = xfer ? cur : 4'd0;
    assign bus.memAddr  = xfer ? addr_q : 32'd0;
    assign bus.wbEn     = wbEn_q;
    assign bus.wbDest   = wbDest_q;
    assign bus.wbData   = wbData_q;
endmodule

// File: tb/tb_block_transfer_ctrl.sv
// Scoreboard bench for block_transfer_ctrl: directed plan cases plus
// randomized transfers against a list/arithmetic reference model.
module tb_block_transfer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_transfer_ctrl_if bus();

    block_transfer_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  r;
    } acc_t;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
        logic        base;
    } wb_t;

    acc_t accQ[$];
    wb_t  wbQ[$];
    int   nQ[$];
    int   patQ[$];
    int   checks = 0;
    int   errors = 0;
    int   rdyMode = 0;
    bit   abort = 1'b0;
    logic [31:0] salt = 32'h1234_5678;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: ready pattern and data for the current address
    always @(posedge clk) begin
        #1;
        if (rdyMode == 2 && (bus.memRead || bus.memWrite) && patQ.size() > 0)
            bus.memReady = (patQ.pop_front() != 0);
        else if (rdyMode == 1)
            bus.memReady = ($urandom_range(0, 2) != 0);
        else
            bus.memReady = 1'b1;
        bus.memRdata = memrd(bus.memAddr);
    end

    // Monitor: pops expectations whenever the DUT presents an event
    int busyCnt = 0;
    int waits = 0;
    logic        pWait = 1'b0;
    logic [31:0] pAddr;
    logic [3:0]  pSel;
    logic        pRd, pWr;
    always @(negedge clk) begin
        acc_t a;
        wb_t  w;
        int   n;
        logic strobe;
        if (rst || abort) begin
            busyCnt = 0;
            waits = 0;
            pWait = 1'b0;
        end else begin
            strobe = bus.memRead || bus.memWrite;
            if (bus.wbEn) begin
                if (wbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected actual %0d/%h expected none",
                             bus.wbDest, bus.wbData);
                end else begin
                    w = wbQ.pop_front();
                    chk("wb_dest", 64'(bus.wbDest), 64'(w.dest));
                    chk("wb_data", 64'(bus.wbData), 64'(w.data));
                    chk("wb_in_done", 64'(bus.done), 64'(w.base));
                end
            end
            if (pWait)
                chk("hold_while_wait",
                    {27'b0, bus.memAddr, bus.regSel, bus.memRead, bus.memWrite},
                    {27'b0, pAddr, pSel, pRd, pWr});
            if (bus.memRead && bus.memWrite)
                chk("both_strobes", 64'd1, 64'd0);
            if (strobe && bus.memReady) begin
                if (accQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL acc_unexpected actual %h expected none",
                             bus.memAddr);
                end else begin
                    a = accQ.pop_front();
                    chk("acc_addr", 64'(bus.memAddr), 64'(a.addr));
                    chk("acc_write", 64'(bus.memWrite), 64'(a.wr));
                    chk("acc_regsel", 64'(bus.regSel), 64'(a.r));
                end
            end
            if (bus.busy) busyCnt++;
            if (strobe && !bus.memReady) waits++;
            if (bus.done) begin
                if (nQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual 1 expected 0");
                end else begin
                    n = nQ.pop_front();
                    chk("busy_len", 64'(busyCnt),
                        64'((n == 0) ? 1 : n + 2 + waits));
                    chk("acc_left", 64'(accQ.size()), 64'd0);
                    chk("wb_left", 64'(wbQ.size()), 64'd0);
                end
                busyCnt = 0;
                waits = 0;
            end
            pWait = strobe && !bus.memReady;
            pAddr = bus.memAddr;
            pSel  = bus.regSel;
            pRd   = bus.memRead;
            pWr   = bus.memWrite;
        end
    end

    // Reference model: ascending register list, lowest register lowest address
    task automatic model(input bit ld, input logic [15:0] list,
                         input logic [31:0] base, input logic [3:0] br,
                         input bit wb);
        int n = 0;
        int k = 0;
        logic [31:0] fin, lo, a;
        for (int r = 0; r < 15; r++) if (list[r]) n++;
        fin = ld ? base + 32'(4 * n) : base - 32'(4 * n);
        lo  = ld ? base : fin;
        for (int r = 0; r < 15; r++) begin
            if (list[r]) begin
                a = lo + 32'(4 * k);
                accQ.push_back('{a, !ld, 4'(r)});
                if (ld) wbQ.push_back('{4'(r), memrd(a), 1'b0});
                k++;
            end
        end
        if (n > 0 && wb && !(ld && br != 4'd15 && list[br]))
            wbQ.push_back('{br, fin, 1'b1});
        nQ.push_back(n);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy !== 1'b0 && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 500) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual busy expected idle");
        end
    endtask

    task automatic drive(input bit ld, input logic [15:0] list,
                         input logic [31:0] base, input logic [3:0] br,
                         input bit wb);
        bus.start     = 1'b1;
        bus.isLoad    = ld;
        bus.regList   = list;
        bus.baseIn    = base;
        bus.baseReg   = br;
        bus.writeBack = wb;
    endtask

    task automatic issue(input bit ld, input logic [15:0] list,
                         input logic [31:0] base, input logic [3:0] br,
                         input bit wb, input int mode);
        @(posedge clk);
        #1;
        wait_idle();
        rdyMode = mode;
        salt = $urandom;
        model(ld, list, base, br, wb);
        drive(ld, list, base, br, wb);
        @(posedge clk);
        #1;
        // A start held while busy must be ignored
        drive(!ld, 16'($urandom), $urandom, 4'($urandom), 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctl"},
            {55'b0, bus.busy, bus.done, bus.memRead, bus.memWrite,
             bus.wbEn, bus.regSel},
            64'd0);
        chk({nm, "_data"}, {bus.memAddr, bus.wbData}, 64'd0);
        chk({nm, "_dest"}, 64'(bus.wbDest), 64'd0);
    endtask

    initial begin
        logic [15:0] lst;
        logic [31:0] b;
        bus.start     = 1'b0;
        bus.isLoad    = 1'b0;
        bus.regList   = '0;
        bus.baseIn    = '0;
        bus.baseReg   = '0;
        bus.writeBack = 1'b0;
        bus.memReady  = 1'b1;
        bus.memRdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        issue(1'b0, 16'h4012, 32'h0000_1000, 4'd13, 1'b1, 0);
        mem[32'h0FF4] = 32'hA;
        mem[32'h0FF8] = 32'hB;
        issue(1'b1, 16'h0005, 32'h0000_0FF4, 4'd13, 1'b1, 0);
        mem.delete();
        issue(1'b1, 16'h2001, 32'h0000_2000, 4'd13, 1'b1, 0);
        patQ = '{0, 0, 0, 1};
        issue(1'b0, 16'h0020, 32'h0000_0400, 4'd2, 1'b1, 2);
        issue(1'b0, 16'h8000, 32'h0000_0800, 4'd13, 1'b1, 0);
        issue(1'b1, 16'h8000, 32'h0000_0800, 4'd13, 1'b1, 0);
        issue(1'b1, 16'h0003, 32'hFFFF_FFFC, 4'd5, 1'b1, 0);

        // Abort a 3-register pop during its second access
        @(posedge clk);
        #1;
        rdyMode = 0;
        model(1'b1, 16'h0007, 32'h0000_3000, 4'd9, 1'b1);
        drive(1'b1, 16'h0007, 32'h0000_3000, 4'd9, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("abort");
        accQ.delete();
        wbQ.delete();
        nQ.delete();
        abort = 1'b0;
        repeat (5) @(posedge clk);
        issue(1'b1, 16'h0007, 32'h0000_3000, 4'd9, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: lst = 16'($urandom);
                1: lst = 16'(1) << $urandom_range(0, 15);
                2: lst = 16'h7FFF;
                3: lst = 16'($urandom) & 16'($urandom);
                default: lst = 16'($urandom) | 16'h8000;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            issue(1'($urandom), lst, b, 4'($urandom),
                  1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk("final_nq", 64'(nQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
